johnson_led: RTL and testbench

Drives a WIDTH-bit LED bank with a Johnson (twisted-ring) pattern that steps once per TICK+1 clocks. It sits directly downstream of the key debouncer and takes two debounced toggle levels: one starts and stops the pattern, the other reverses its direction. Each level change on those inputs counts as exactly one button press. The `led` outputs go straight to board pins.

---
 rtl/johnson_led_if.sv | 23 ++
 rtl/johnson_led.sv | 90 +++++++++
 tb/tb_johnson_led.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/johnson_led_if.sv
// Control and display signals between the LED sequencer and whatever drives it.
// The master side drives the debounced toggles and clear; the slave is the sequencer.
interface johnson_led_if #(
  parameter int unsigned WIDTH = 4
);
  logic             run_tog;
  logic             dir_tog;
  logic             clr;
  logic [WIDTH-1:0] led;
  logic             running;
  logic             dir;
  logic             step;

  modport master (
    output run_tog, dir_tog, clr,
    input  led, running, dir, step
  );

  modport slave (
    input  run_tog, dir_tog, clr,
    output led, running, dir, step
  );
endinterface

// File: rtl/johnson_led.sv
// Johnson-ring LED sequencer stepping every TICK+1 clocks, with run/stop and
// direction controlled by level changes on two debounced toggle inputs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_STOP | prescaler held at 0, led frozen, waiting for a run press
//   ST_RUN  | prescaler counting, led shifts on each terminal count
module johnson_led #(
  parameter int unsigned      WIDTH = 4,
  parameter int unsigned      CNT_W = 24,
  parameter logic [CNT_W-1:0] TICK  = 24'd12_499_999
) (
  input  logic        clk,
  input  logic        rst_n,
  johnson_led_if.slave bus
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             run_d;
  logic             dir_d;
  logic             run_ev;
  logic             dir_ev;
  logic             tick;
  logic             shift;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] led_nx;
  logic             dir_q;
  logic             step_q;

  assign run_ev = bus.run_tog ^ run_d;
  assign dir_ev = bus.dir_tog ^ dir_d;
  assign tick   = (state_q == ST_RUN) && (cnt_q == TICK);
  // A stop press or a clear on the terminal-count edge swallows that shift.
  assign shift  = tick && !bus.clr && !run_ev;
  assign led_nx = dir_q ? {~led_q[0], led_q[WIDTH-1:1]}
                        : {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= ST_STOP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.clr && run_ev) begin
      case (state_q)
        ST_STOP: state_d = ST_RUN;
        ST_RUN:  state_d = ST_STOP;
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_comb begin
    bus.running = (state_q == ST_RUN);
    bus.led     = led_q;
    bus.dir     = dir_q;
    bus.step    = step_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      run_d  <= 1'b0;
      dir_d  <= 1'b0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
      led_q  <= '0;
    end else begin
      run_d  <= bus.run_tog;
      dir_d  <= bus.dir_tog;
      dir_q  <= dir_q ^ dir_ev;
      step_q <= shift;

      if (bus.clr || state_q == ST_STOP || run_ev || tick) cnt_q <= '0;
      else                                                 cnt_q <= cnt_q + CNT_W'(1);

      if (bus.clr)    led_q <= '0;
      else if (shift) led_q <= led_nx;
    end
  end

endmodule

// File: tb/tb_johnson_led.sv
// Randomized scoreboard bench for johnson_led: a ring-position model predicts
// per-edge status and every step pulse; a negedge monitor compares.
module tb_johnson_led;
  localparam int W    = 4;
  localparam int TICK = 3;

  logic clk;
  logic rst_n;

  johnson_led_if #(.WIDTH(W)) bus ();

  johnson_led #(.WIDTH(W), .CNT_W(24), .TICK(24'd3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         tag;
    logic [W-1:0] led;
    logic       running;
    logic       dir;
  } st_t;

  typedef struct {
    int         tag;
    logic [W-1:0] led;
  } sh_t;

  st_t stq[$];
  sh_t shq[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // reference model: ring position 0..2W-1, plus run/dir flags and period phase
  int   m_p;
  bit   m_run;
  bit   m_dir;
  int   m_phase;
  bit   m_prev_run;
  bit   m_prev_dir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [W-1:0] pat(input int p);
    int v;
    if (p <= W) v = (1 << p) - 1;
    else        v = ~((1 << (p - W)) - 1);
    return W'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, edge_n, got, exp);
    end
  endtask

  task automatic drive_cycle(input bit r, input bit rt, input bit dt, input bit c);
    bit  rev, dev, sh;
    int  tag;
    st_t s;
    sh_t e;
    tag = edge_n + 1;
    rst_n       = r;
    bus.run_tog = rt;
    bus.dir_tog = dt;
    bus.clr     = c;
    sh = 1'b0;
    if (r) begin
      m_p = 0; m_run = 0; m_dir = 0; m_phase = 0; m_prev_run = 0; m_prev_dir = 0;
    end else begin
      rev = (rt != m_prev_run);
      dev = (dt != m_prev_dir);
      if (c) begin
        m_p = 0; m_phase = 0;
      end else if (rev) begin
        m_run = !m_run; m_phase = 0;
      end else if (m_run) begin
        if (m_phase == TICK) begin
          sh = 1'b1;
          m_p = m_dir ? (m_p + 2*W - 1) % (2*W) : (m_p + 1) % (2*W);
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (dev) m_dir = !m_dir;
      m_prev_run = rt;
      m_prev_dir = dt;
    end
    s.tag = tag; s.led = pat(m_p); s.running = m_run; s.dir = m_dir;
    stq.push_back(s);
    if (sh) begin
      e.tag = tag; e.led = pat(m_p);
      shq.push_back(e);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    st_t s;
    sh_t e;
    if (stq.size() > 0 && stq[0].tag == edge_n) begin
      s = stq.pop_front();
      chk("led",     32'(bus.led),     32'(s.led));
      chk("running", 32'(bus.running), 32'(s.running));
      chk("dir",     32'(bus.dir),     32'(s.dir));
    end
    if (bus.step) begin
      checks++;
      if (shq.size() > 0 && shq[0].tag == edge_n) begin
        e = shq.pop_front();
        if (bus.led !== e.led) begin
          errors++;
          $display("FAIL step_led edge=%0d got=%b exp=%b", edge_n, bus.led, e.led);
        end
      end else begin
        errors++;
        $display("FAIL spurious_step edge=%0d got step=1 exp step=0", edge_n);
      end
    end else if (shq.size() > 0 && shq[0].tag == edge_n) begin
      e = shq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_step edge=%0d got step=0 exp step=1 led=%b", edge_n, e.led);
    end
  end

  initial begin
    bit r, rt, dt, c;
    rst_n = 1'b1; bus.run_tog = 1'b0; bus.dir_tog = 1'b0; bus.clr = 1'b0;
    m_p = 0; m_run = 0; m_dir = 0; m_phase = 0; m_prev_run = 0; m_prev_dir = 0;

    // reset hold, then idle
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(0, 0, 0, 0);

    // one full left lap from a single run press
    drive_cycle(0, 1, 0, 0);
    for (int i = 0; i < 36; i++) drive_cycle(0, 1, 0, 0);

    // random presses, clears and resets, biased toward terminal-count collisions
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      rt = bus.run_tog;
      dt = bus.dir_tog;
      c  = 1'b0;
      if (m_run && m_phase == TICK && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) rt = ~rt;
        else                           c  = 1'b1;
      end else if ($urandom_range(0, m_run ? 49 : 5) == 0) begin
        rt = ~rt;
      end else if ($urandom_range(0, 79) == 0) begin
        c = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) dt = ~dt;
      drive_cycle(r, rt, dt, c);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (shq.size() != 0) begin
      errors++;
      $display("FAIL step_drain got=%0d pending exp=0", shq.size());
    end
    checks++;
    if (stq.size() != 0) begin
      errors++;
      $display("FAIL status_drain got=%0d pending exp=0", stq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
